// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store initiator with read-modify-write for sub-word stores
// Core side : req_valid/req_ready/req_store/req_funct3/req_addr/req_wdata in, rsp_valid/rsp_ready/rsp_rdata/rsp_err out
// Memory    : A byte address, WD write data, WE write enable, RD combinational read data of word at A
module lsu_mem_port #(
  parameter int MEM_WORDS = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        WE,
  input  logic [31:0] RD
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;
  state_e state_q, state_d;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q, merge_d, rdata_d, rsh, mask, lanes;
  logic [2:0] f3_q;
  logic store_q, err_q, f3_ok, mis, oor, req_err, acc, done;
  assign acc = req_valid && req_ready;
  assign done = state_q == RESP && rsp_ready;
  // store codes 000..010; loads additionally 100/101
  assign f3_ok = req_store ? req_funct3 < 3'd3 : req_funct3[1:0] != 2'b11 && req_funct3 != 3'b110;
  assign mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign oor = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
  assign req_err = !f3_ok || mis || oor;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !req_valid ? IDLE : req_err ? RESP : !req_store ? LOAD : req_funct3[1] ? WRITE : RMW_RD;
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      default: state_d = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_comb begin
    req_ready = state_q == IDLE;
    rsp_valid = state_q == RESP;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    A  = state_q inside {LOAD, RMW_RD, WRITE} ? {addr_q[31:2], 2'b00} : 32'd0;
    WE = state_q == WRITE;
    WD = state_q != WRITE ? 32'd0 : f3_q[1] ? wdata_q : merge_q;
  end
  // f3_q[1] marks a full word, f3_q[0] a halfword, f3_q[2] zero-extension
  always_comb begin
    rsh     = RD >> {addr_q[1:0], 3'b000};
    rdata_d = f3_q[1] ? RD :
              f3_q[0] ? {{16{~f3_q[2] & rsh[15]}}, rsh[15:0]} : {{24{~f3_q[2] & rsh[7]}}, rsh[7:0]};
    mask    = f3_q[0] ? 32'h0000_FFFF << {addr_q[1], 4'b0000} : 32'h0000_00FF << {addr_q[1:0], 3'b000};
    lanes   = f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    merge_d = (RD & ~mask) | (lanes & mask);
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (acc) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
        store_q <= req_store;
      end
      if (state_q == RMW_RD) merge_q <= merge_d;
      rdata_q <= state_q == LOAD ? rdata_d : done ? 32'd0 : rdata_q;
      err_q   <= acc ? req_err : done ? 1'b0 : err_q;
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0, rsp_ready = 1'b1;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, WE;
  logic [31:0] rsp_rdata, A, WD, RD;
  logic [31:0] mem [64];
  logic [31:0] last_wd = '0, hold;
  int errors = 0, checks = 0, we_cnt = 0, we0 = 0;

  lsu_mem_port #(.MEM_WORDS(64)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .A(A), .WD(WD), .WE(WE), .RD(RD)
  );

  always #5 CLK = ~CLK;
  assign RD = mem[A[7:2]];
  always @(posedge CLK) if (WE) mem[A[7:2]] <= WD;
  always @(negedge CLK) if (WE) begin we_cnt++; last_wd = WD; end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic send(input logic st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    req_valid = 1'b1; req_store = st; req_funct3 = f; req_addr = a; req_wdata = d;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    we0 = we_cnt;
  endtask

  task automatic wait_rsp(input string tag, input int lat, input logic [31:0] rd, input logic er, input int wes);
    int n = 0;
    while (!rsp_valid && n < 8) begin @(posedge CLK); #1; n++; end
    chk({tag, " latency"}, n, lat);
    chk({tag, " rdata"}, rsp_rdata, rd);
    chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, er});
    chk({tag, " writes"}, we_cnt - we0, wes);
  endtask

  task automatic consume(input string tag);
    @(posedge CLK); #1;
    chk({tag, " idle"}, {rsp_valid, req_ready, rsp_err}, 3'b010);
    chk({tag, " rdata clr"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    mem[3]  = 32'h1122_3344;
    mem[4]  = 32'h8081_7F01;
    mem[63] = 32'hCAFE_F00D;
    #12;
    chk("rst ctl", {req_ready, rsp_valid, rsp_err, WE}, 4'b1000);
    chk("rst A", A, 32'd0);
    chk("rst WD", WD, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    @(negedge CLK) RST_N = 1'b1;

    send(0, 3'b000, 32'h12, 0); wait_rsp("lb12", 1, 32'hFFFF_FF81, 0, 0); consume("lb12");
    send(0, 3'b000, 32'h11, 0); wait_rsp("lb11", 1, 32'h0000_007F, 0, 0); consume("lb11");
    send(0, 3'b100, 32'h12, 0); wait_rsp("lbu12", 1, 32'h0000_0081, 0, 0); consume("lbu12");
    send(0, 3'b001, 32'h12, 0); wait_rsp("lh12", 1, 32'hFFFF_8081, 0, 0); consume("lh12");
    send(0, 3'b101, 32'h10, 0); wait_rsp("lhu10", 1, 32'h0000_7F01, 0, 0); consume("lhu10");
    send(0, 3'b010, 32'h10, 0); wait_rsp("lw10", 1, 32'h8081_7F01, 0, 0); consume("lw10");
    send(0, 3'b010, 32'hFC, 0); wait_rsp("lw top", 1, 32'hCAFE_F00D, 0, 0); consume("lw top");

    send(1, 3'b000, 32'h12, 32'h5555_55AB); wait_rsp("sb12", 2, 32'd0, 0, 1);
    chk("sb12 WD", last_wd, 32'h80AB_7F01);
    consume("sb12");
    send(0, 3'b010, 32'h10, 0); wait_rsp("lw after sb", 1, 32'h80AB_7F01, 0, 0); consume("lw after sb");
    send(1, 3'b001, 32'h10, 32'hFFFF_1234); wait_rsp("sh10", 2, 32'd0, 0, 1); consume("sh10");
    chk("mem4 after sh", mem[4], 32'h80AB_1234);

    send(0, 3'b010, 32'h02, 0); wait_rsp("err lw mis", 0, 32'd0, 1, 0); consume("err lw mis");
    send(1, 3'b001, 32'h01, 0); wait_rsp("err sh mis", 0, 32'd0, 1, 0); consume("err sh mis");
    send(0, 3'b011, 32'h10, 0); wait_rsp("err f3 011", 0, 32'd0, 1, 0); consume("err f3 011");
    send(1, 3'b100, 32'h10, 0); wait_rsp("err st f3", 0, 32'd0, 1, 0); consume("err st f3");
    send(1, 3'b010, 32'h100, 32'h1); wait_rsp("err range", 0, 32'd0, 1, 0); consume("err range");

    rsp_ready = 1'b0;
    send(0, 3'b010, 32'h10, 0); wait_rsp("bp lw", 1, 32'h80AB_1234, 0, 0);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
    hold = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk("bp hold ctl", {rsp_valid, req_ready, WE}, 3'b100);
      chk("bp hold rdata", rsp_rdata, hold);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    consume("bp release");
    chk("bp no write", mem[0], 32'd0);

    send(1, 3'b010, 32'h0C, 32'hDEAD_BEEF);
    chk("rst mid WE on", {31'd0, WE}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst mid WE drop", {31'd0, WE}, 32'd0);
    chk("rst mid A", A, 32'd0);
    @(negedge CLK); @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rst mid mem3", mem[3], 32'h1122_3344);
    chk("rst mid ctl", {req_ready, rsp_valid, rsp_err, WE}, 4'b1000);
    chk("rst mid outs", A | WD | rsp_rdata, 32'd0);

    send(1, 3'b010, 32'h00, 32'hA5A5_A5A5); wait_rsp("b2b sw0", 1, 32'd0, 0, 1);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'hFC; req_wdata = 32'h5A5A_5A5A;
    @(posedge CLK); #1;
    chk("b2b idle", {req_ready, rsp_valid}, 2'b10);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    chk("b2b accept", {req_ready, WE}, 2'b01);
    chk("b2b A", A, 32'hFC);
    @(posedge CLK); #1;
    chk("b2b rsp", {rsp_valid, rsp_err}, 2'b10);
    consume("b2b sw63");
    chk("b2b mem0", mem[0], 32'hA5A5_A5A5);
    chk("b2b mem63", mem[63], 32'h5A5A_5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
